instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Multicycle fetch stage directly upstream of the instruction register/decoder.
//  Holds the PC and runs a req/ready read of instruction memory.
//  Latches the returned 16-bit word and presents it, stable, to the decoder until control requests the next fetch.
//  Supports PC redirect (branch/jump) from the control unit.
// PARAMETERS
//  ADDR_W    16      PC / instruction memory address width (word addressed)
//  RESET_PC  16'h0000  PC value after reset
// PORTS
//  clk          in   1       clock; all state changes on posedge
//  reset        in   1       synchronous, active-high reset
//  fetch_en     in   1       control unit: start fetch of instruction at pc
//  pc_load      in   1       control unit: redirect pc to pc_load_val
//  pc_load_val  in   ADDR_W  redirect target
//  imem_req     out  1       read request to instruction memory
//  imem_addr    out  ADDR_W  read address (= pc while imem_req=1)
//  imem_ready   in   1       imem_rdata valid for imem_addr this cycle
//  imem_rdata   in   16      instruction word from memory
//  instr        out  16      latched instruction word, feeds decoder
//  instr_valid  out  1       instr holds a freshly fetched word
//  instr_pc     out  ADDR_W  address instr was fetched from
//  pc_plus1     out  ADDR_W  instr_pc+1 (link/next-sequential value), combinational
//  pc           out  ADDR_W  address of next fetch
//  busy         out  1       1 while state=WAIT
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Reset values (also on reset mid-operation, any state):
//   state=IDLE, pc=RESET_PC, instr=16'h0000, instr_pc=RESET_PC, instr_valid=0, imem_req=0.
//   An in-flight memory response is discarded.
//  FSM states: IDLE, WAIT, VALID.
//   IDLE: imem_req=0, instr_valid=0. fetch_en=1 -> WAIT.
//   WAIT: imem_req=1, imem_addr=pc; fetch_en ignored.
//    imem_ready=1 & pc_load=0 -> instr<=imem_rdata, instr_pc<=pc, pc<=pc+1, instr_valid<=1, -> VALID.
//    imem_ready=1 & pc_load=1 -> word dropped, pc<=pc_load_val, stay WAIT; next cycle reissues at the new pc.
//    imem_ready=0 & pc_load=1 -> pc<=pc_load_val, stay WAIT; imem_addr follows pc.
//   VALID: instr, instr_pc, instr_valid=1 held stable.
//    fetch_en=1 -> instr_valid<=0, -> WAIT; instr keeps its old value until overwritten.
//  pc_load outside WAIT: pc<=pc_load_val.
//   Has priority over the increment and applies in any state.
//   pc_load and fetch_en in the same cycle: load first, fetch uses the new pc.
//  imem_addr is driven from the pc register only; no combinational path from pc_load_val to imem_addr.
//  Latency: fetch_en at cycle N -> imem_req=1 at N+1.
//   Zero-wait memory (ready at N+1) -> instr_valid=1 at N+2.
//   Each extra wait cycle adds one cycle.
//  Arithmetic: pc+1 and pc_plus1 are modulo 2^ADDR_W; FFFF wraps to 0000.
//  imem_req deasserts the cycle after the accepting imem_ready; there are no back-to-back requests without fetch_en.
// TESTING
//  1 Reset: assert reset 2 cycles -> pc=0000, instr=0000, instr_valid=0, imem_req=0, busy=0.
//  2 Zero-wait fetch: fetch_en pulse @N, ready=1, rdata=16'h3501 ->
//     req@N+1 addr=0000; valid@N+2, instr=3501, instr_pc=0000, pc=0001, pc_plus1=0001.
//  3 Wait states: 2nd fetch with ready low 3 cycles ->
//     imem_req=1 and addr=0001 stable 4 cycles; valid only after ready; instr unchanged until then.
//  4 Redirect in VALID: pc_load=1, val=0040, fetch_en=1 same cycle ->
//     next req addr=0040; instr_pc=0040 after return.
//  5 Redirect in WAIT with ready=1 same cycle, rdata=16'hBEEF ->
//     BEEF not latched, valid stays 0, req continues at new pc, next returned word latched.
//  6 Wrap/reset: pc_load FFFF, fetch -> instr_pc=FFFF, pc=0000, pc_plus1=0000;
//     then reset during WAIT -> IDLE, req=0, pc=0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle PC/fetch stage with req/ready imem read, latched instruction and PC redirect
module instr_fetch_unit #(
   parameter int ADDR_W = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_val,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [15:0]       imem_rdata,
   output logic [15:0]       instr,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [ADDR_W-1:0] pc_plus1,
   output logic [ADDR_W-1:0] pc,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, instr_pc_q, instr_pc_d;
   logic [15:0] instr_q, instr_d;
   always_comb begin
      state_d = state_q;
      pc_d = pc_load ? pc_load_val : pc_q;
      instr_d = instr_q;
      instr_pc_d = instr_pc_q;
      case (state_q)
         IDLE: state_d = fetch_en ? WAIT : IDLE;
         WAIT: if (imem_ready && !pc_load) begin
            instr_d = imem_rdata;
            instr_pc_d = pc_q;
            pc_d = pc_q + ADDR_W'(1);
            state_d = VALID;
         end
         VALID: state_d = fetch_en ? WAIT : VALID;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q <= RESET_PC;
         instr_q <= '0;
         instr_pc_q <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         instr_q <= instr_d;
         instr_pc_q <= instr_pc_d;
      end
   end
   // address comes straight from the pc register, never from pc_load_val
   assign imem_req = state_q == WAIT;
   assign busy = state_q == WAIT;
   assign imem_addr = pc_q;
   assign pc = pc_q;
   assign instr = instr_q;
   assign instr_pc = instr_pc_q;
   assign instr_valid = state_q == VALID;
   assign pc_plus1 = instr_pc_q + ADDR_W'(1);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table, wrap/reset sequence and randomized run against a behavioural model
module tb_instr_fetch_unit;
   logic clk = 0, reset, fetch_en, pc_load, imem_ready;
   logic [15:0] pc_load_val, imem_rdata;
   logic imem_req, instr_valid, busy;
   logic [15:0] imem_addr, instr, instr_pc, pc_plus1, pc;
   int errors = 0, checks = 0;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_load(pc_load),
      .pc_load_val(pc_load_val), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
      .instr_valid(instr_valid), .instr_pc(instr_pc), .pc_plus1(pc_plus1),
      .pc(pc), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, fe, pl;
      logic [15:0] val;
      logic rdy;
      logic [15:0] rd;
      logic req;
      logic [15:0] addr;
      logic vld;
      logic [15:0] ins, ipc, npc;
   } vec_t;

   vec_t tbl[19];

   // behavioural model: is a request outstanding, is a fresh word held
   logic m_pend, m_have;
   logic [15:0] m_pc, m_ins, m_ipc;

   function automatic vec_t mk(logic rst, logic fe, logic pl, logic [15:0] val, logic rdy, logic [15:0] rd,
                               logic req, logic vld, logic [15:0] ins, logic [15:0] ipc, logic [15:0] npc);
      vec_t v;
      v.rst = rst; v.fe = fe; v.pl = pl; v.val = val; v.rdy = rdy; v.rd = rd;
      v.req = req; v.addr = npc; v.vld = vld; v.ins = ins; v.ipc = ipc; v.npc = npc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic fe, input logic pl, input logic [15:0] val,
                        input logic rdy, input logic [15:0] rd);
      reset = rst; fetch_en = fe; pc_load = pl; pc_load_val = val; imem_ready = rdy; imem_rdata = rd;
      if (rst) begin
         m_pend = 0; m_have = 0; m_pc = 16'h0000; m_ins = 16'h0000; m_ipc = 16'h0000;
      end else if (m_pend) begin
         if (pl) m_pc = val;
         else if (rdy) begin
            m_ins = rd; m_ipc = m_pc; m_pc = m_pc + 16'd1; m_pend = 0; m_have = 1;
         end
      end else begin
         if (pl) m_pc = val;
         if (fe) begin m_pend = 1; m_have = 0; end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".req"}, {15'd0, imem_req}, {15'd0, m_pend});
      chk({tag, ".busy"}, {15'd0, busy}, {15'd0, m_pend});
      chk({tag, ".addr"}, imem_addr, m_pc);
      chk({tag, ".pc"}, pc, m_pc);
      chk({tag, ".valid"}, {15'd0, instr_valid}, {15'd0, m_have});
      chk({tag, ".instr"}, instr, m_ins);
      chk({tag, ".instr_pc"}, instr_pc, m_ipc);
      chk({tag, ".pc_plus1"}, pc_plus1, m_ipc + 16'd1);
   endtask

   initial begin
      //            rst fe pl val       rdy rd        req vld instr     ipc       pc
      tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[1]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[2]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[3]  = mk(0, 0, 0, 16'h0000, 1, 16'h3501, 0, 1, 16'h3501, 16'h0000, 16'h0001);
      tbl[4]  = mk(0, 0, 0, 16'h0000, 1, 16'h9999, 0, 1, 16'h3501, 16'h0000, 16'h0001);
      tbl[5]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h3501, 16'h0000, 16'h0001);
      tbl[6]  = mk(0, 1, 0, 16'h0000, 0, 16'h7777, 1, 0, 16'h3501, 16'h0000, 16'h0001);
      tbl[7]  = mk(0, 0, 0, 16'h0000, 0, 16'h7777, 1, 0, 16'h3501, 16'h0000, 16'h0001);
      tbl[8]  = mk(0, 0, 0, 16'h0000, 0, 16'h7777, 1, 0, 16'h3501, 16'h0000, 16'h0001);
      tbl[9]  = mk(0, 0, 0, 16'h0000, 1, 16'hA5A5, 0, 1, 16'hA5A5, 16'h0001, 16'h0002);
      tbl[10] = mk(0, 1, 1, 16'h0040, 0, 16'h0000, 1, 0, 16'hA5A5, 16'h0001, 16'h0040);
      tbl[11] = mk(0, 0, 0, 16'h0000, 1, 16'h1234, 0, 1, 16'h1234, 16'h0040, 16'h0041);
      tbl[12] = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h1234, 16'h0040, 16'h0041);
      tbl[13] = mk(0, 0, 1, 16'h0100, 1, 16'hBEEF, 1, 0, 16'h1234, 16'h0040, 16'h0100);
      tbl[14] = mk(0, 0, 1, 16'h0200, 0, 16'h0000, 1, 0, 16'h1234, 16'h0040, 16'h0200);
      tbl[15] = mk(0, 0, 0, 16'h0000, 1, 16'h5678, 0, 1, 16'h5678, 16'h0200, 16'h0201);
      tbl[16] = mk(0, 0, 1, 16'h0300, 0, 16'h0000, 0, 1, 16'h5678, 16'h0200, 16'h0300);
      tbl[17] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      tbl[18] = mk(0, 0, 1, 16'h0010, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0010);
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].rst, tbl[i].fe, tbl[i].pl, tbl[i].val, tbl[i].rdy, tbl[i].rd);
         chk($sformatf("vec%0d.req", i), {15'd0, imem_req}, {15'd0, tbl[i].req});
         chk($sformatf("vec%0d.busy", i), {15'd0, busy}, {15'd0, tbl[i].req});
         chk($sformatf("vec%0d.addr", i), imem_addr, tbl[i].addr);
         chk($sformatf("vec%0d.pc", i), pc, tbl[i].npc);
         chk($sformatf("vec%0d.valid", i), {15'd0, instr_valid}, {15'd0, tbl[i].vld});
         chk($sformatf("vec%0d.instr", i), instr, tbl[i].ins);
         chk($sformatf("vec%0d.instr_pc", i), instr_pc, tbl[i].ipc);
         chk($sformatf("vec%0d.pc_plus1", i), pc_plus1, tbl[i].ipc + 16'd1);
      end
      // wrap at FFFF, then reset in the middle of a fetch
      drive(0, 1, 1, 16'hFFFF, 0, 16'h0000);
      chk("wrap.addr", imem_addr, 16'hFFFF);
      drive(0, 0, 0, 16'h0000, 1, 16'h0F0F);
      chk("wrap.valid", {15'd0, instr_valid}, 16'd1);
      chk("wrap.instr", instr, 16'h0F0F);
      chk("wrap.instr_pc", instr_pc, 16'hFFFF);
      chk("wrap.pc", pc, 16'h0000);
      chk("wrap.pc_plus1", pc_plus1, 16'h0000);
      drive(0, 1, 1, 16'h1111, 0, 16'h0000);
      chk("mid.req", {15'd0, imem_req}, 16'd1);
      drive(1, 0, 0, 16'h0000, 1, 16'hDEAD);
      chk("rst.req", {15'd0, imem_req}, 16'd0);
      chk("rst.busy", {15'd0, busy}, 16'd0);
      chk("rst.pc", pc, 16'h0000);
      chk("rst.valid", {15'd0, instr_valid}, 16'd0);
      chk("rst.instr", instr, 16'h0000);
      drive(0, 0, 0, 16'h0000, 1, 16'hDEAD);
      chk("post.req", {15'd0, imem_req}, 16'd0);
      chk("post.instr", instr, 16'h0000);
      // randomized run against the model
      drive(1, 0, 0, 16'h0000, 0, 16'h0000);
      chk_model("rnd.reset");
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 6) == 0,
               16'($urandom), $urandom_range(0, 2) != 0, 16'($urandom));
         chk_model($sformatf("rnd%0d", i));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
